// File: rtl/delay_arbiter.sv
// delay_arbiter: one prescaled delay timer shared by NREQ requesters.
// Round-robin grant by default; DELAY_ARB_FIXED_PRIO_EN selects fixed priority.
module delay_arbiter #(
   parameter int NREQ     = 4,
   parameter int CNT_WDTH = 30,
   parameter int PRESCALE = 100
) (
   input  logic                     mclk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*CNT_WDTH-1:0] dly,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     busy,
   output logic                     tick
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_DONE
   } state_t;

   state_t                state;
   state_t                state_n;
   logic [NREQ-1:0]       gnt_n;
   logic [NREQ-1:0]       done_n;
   logic                  busy_n;
   logic                  tick_n;
   logic [CNT_WDTH-1:0]   pre;
   logic [CNT_WDTH-1:0]   pre_n;
   logic [CNT_WDTH-1:0]   rem;
   logic [CNT_WDTH-1:0]   rem_n;
   logic [IW-1:0]         cur;
   logic [IW-1:0]         cur_n;
   logic [IW-1:0]         base;
   logic [IW-1:0]         win;
   logic                  found;
   logic                  rel;
   logic                  wrap;

`ifndef DELAY_ARB_FIXED_PRIO_EN
   logic [IW-1:0]         ptr;
   logic [IW-1:0]         nxt;

   assign base = ptr;
   assign nxt  = (cur == IW'(NREQ - 1)) ? '0 : cur + 1'b1;

   // Rotate the search start past the requester whose job just ended.
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (rel) begin
         ptr <= nxt;
      end
   end
`else
   assign base = '0;
`endif

   assign wrap = (pre == CNT_WDTH'(PRESCALE));

   // Pick the first set request at or above base, wrapping modulo NREQ.
   always_comb begin
      int            s;
      logic [IW-1:0] idx;
      s     = 0;
      idx   = '0;
      found = 1'b0;
      win   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         s = int'(base) + k;
         if (s >= NREQ) begin
            s = s - NREQ;
         end
         idx = IW'(s);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state and next-output logic; all outputs leave as registers.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      done_n  = '0;
      busy_n  = busy;
      tick_n  = 1'b0;
      pre_n   = pre;
      rem_n   = rem;
      cur_n   = cur;
      rel     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               gnt_n      = '0;
               gnt_n[win] = 1'b1;
               busy_n     = 1'b1;
               cur_n      = win;
               pre_n      = '0;
               rem_n      = dly[win*CNT_WDTH +: CNT_WDTH];
               if (rem_n == '0) begin
                  state_n     = S_DONE;
                  done_n[win] = 1'b1;
               end else begin
                  state_n = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (!req[cur]) begin
               // Withdrawal beats a coincident final tick.
               state_n = S_IDLE;
               gnt_n   = '0;
               busy_n  = 1'b0;
               pre_n   = '0;
               rel     = 1'b1;
            end else if (wrap) begin
               pre_n  = '0;
               rem_n  = rem - 1'b1;
               tick_n = 1'b1;
               if (rem == CNT_WDTH'(1)) begin
                  state_n     = S_DONE;
                  done_n[cur] = 1'b1;
               end
            end else begin
               pre_n = pre + 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            rel     = 1'b1;
         end
         default: begin
            state_n = S_IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
         tick  <= 1'b0;
         pre   <= '0;
         rem   <= '0;
         cur   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         done  <= done_n;
         busy  <= busy_n;
         tick  <= tick_n;
         pre   <= pre_n;
         rem   <= rem_n;
         cur   <= cur_n;
      end
   end

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with PRESCALE=3.
// Define DELAY_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_delay_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 8;
   localparam int PS   = 3;

   logic                 mclk;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*CW-1:0]   dly;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic                 busy;
   logic                 tick;

   int checks = 0;
   int errors = 0;

   delay_arbiter #(
      .NREQ(NREQ),
      .CNT_WDTH(CW),
      .PRESCALE(PS)
   ) dut (
      .mclk(mclk),
      .rst(rst),
      .req(req),
      .dly(dly),
      .gnt(gnt),
      .done(done),
      .busy(busy),
      .tick(tick)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_dly(input int i, input int v);
      dly[i*CW +: CW] = v[CW-1:0];
   endtask

   initial begin
      logic [3:0] exp2 [4];
      logic [3:0] exp6 [3];
`ifdef DELAY_ARB_FIXED_PRIO_EN
      exp2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
      exp6 = '{4'b0001, 4'b0001, 4'b0001};
`else
      exp2 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      exp6 = '{4'b0001, 4'b0010, 4'b0100};
`endif
      rst = 1'b0;
      req = '0;
      dly = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tick", 32'(tick), 0);
      rst = 1'b1;
      step();

      // Basic delay of 2 base ticks on requester 0.
      set_dly(0, 2);
      req = 4'b0001;
      step();
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_tick0", 32'(tick), 0);
      for (int c = 1; c <= 9; c++) begin
         step();
         chk($sformatf("t1_tick_c%0d", c), 32'(tick),
             32'((c == 4) || (c == 8)));
         chk($sformatf("t1_done_c%0d", c), 32'(done),
             (c == 8) ? 32'h1 : 32'h0);
         chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 8));
         chk($sformatf("t1_gnt_c%0d", c), 32'(gnt),
             (c <= 8) ? 32'h1 : 32'h0);
         if (c == 8) req = '0;
      end

      // Fresh reset, then two requesters contend with dly=1.
      rst = 1'b0;
      step();
      rst = 1'b1;
      set_dly(0, 1);
      set_dly(2, 1);
      req = 4'b0101;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(exp2[i]));
         for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("t2_nodone%0d_%0d", i, c), 32'(done), 0);
         end
         step();
         chk($sformatf("t2_done%0d", i), 32'(done), 32'(exp2[i]));
         step();
         chk($sformatf("t2_idle_gnt%0d", i), 32'(gnt), 0);
         chk($sformatf("t2_idle_busy%0d", i), 32'(busy), 0);
         if (i == 3) req = '0;
         step();
      end
      chk("t2_end_gnt", 32'(gnt), 0);

      // Zero delay: grant and done together, no tick.
      set_dly(3, 0);
      req = 4'b1000;
      step();
      chk("t3_gnt", 32'(gnt), 32'h8);
      chk("t3_done", 32'(done), 32'h8);
      chk("t3_busy", 32'(busy), 1);
      chk("t3_tick", 32'(tick), 0);
      req = '0;
      step();
      chk("t3_idle_gnt", 32'(gnt), 0);
      chk("t3_idle_busy", 32'(busy), 0);
      chk("t3_idle_done", 32'(done), 0);
      chk("t3_idle_tick", 32'(tick), 0);

      // Cancel of requester 1, then pending requester 2 served.
      set_dly(1, 5);
      set_dly(2, 1);
      req = 4'b0110;
      step();
      chk("t4_gnt1", 32'(gnt), 32'h2);
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("t4_nodone_c%0d", c), 32'(done), 0);
         chk($sformatf("t4_tick_c%0d", c), 32'(tick), 32'(c == 4));
      end
      req = 4'b0100;
      step();
      chk("t4_cancel_gnt", 32'(gnt), 0);
      chk("t4_cancel_busy", 32'(busy), 0);
      chk("t4_cancel_done", 32'(done), 0);
      step();
      chk("t4_gnt2", 32'(gnt), 32'h4);
      for (int c = 1; c <= 3; c++) step();
      step();
      chk("t4_done2", 32'(done), 32'h4);
      req = '0;
      step();
      chk("t4_end_busy", 32'(busy), 0);

      // Asynchronous reset mid-count.
      set_dly(1, 5);
      req = 4'b0010;
      step();
      chk("t5_gnt", 32'(gnt), 32'h2);
      for (int c = 1; c <= 4; c++) step();
      chk("t5_tick", 32'(tick), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_done", 32'(done), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_tick", 32'(tick), 0);
      #1;
      for (int i = 0; i < NREQ; i++) set_dly(i, 1);
      req = 4'b1111;
      rst = 1'b1;
      step();

      // All requesting after reset: grant sequence from requester 0.
      for (int j = 0; j < 3; j++) begin
         if (j > 0) begin
            for (int c = 1; c <= 3; c++) step();
            step();
            chk($sformatf("t6_done%0d", j - 1), 32'(done),
                32'(exp6[j-1]));
            step();
            step();
         end
         chk($sformatf("t6_gnt%0d", j), 32'(gnt), 32'(exp6[j]));
      end
      req = '0;
      for (int c = 0; c < 6; c++) step();
      chk("t6_end_busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
